ui_io_ctrl: RTL and testbench
=============================

Name: ui_io_ctrl

Overview:
Parametrised memory-mapped controller for board UI devices: push keys, slide switches, red LEDs and seven-segment HEX digits. It succeeds the fixed 4-key/10-switch/4-digit controller with configurable device counts and a counter-based debouncer with synchroniser. It adds sticky edge-capture registers and a maskable interrupt request. It sits on the processor I/O bus beside data memory, selected by a register address from the bus decoder.

Parameters:
DBITS, 32, bus data width (must be >= max(NKEYS, NSW, NLEDS, 4*NHEX))
NKEYS, 4, number of key inputs
NSW, 10, number of switch inputs
NLEDS, 10, number of LED outputs
NHEX, 4, number of seven-segment digits (each shows 4 bits)
DEB_CYCLES, 15, consecutive stable synchronised cycles required before the debounced value changes (>= 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
wrtEn  in  1  write strobe, sampled at rising clk
addr  in  3  register select: 0 KEY, 1 SW, 2 LEDR, 3 HEX, 4 KEY_EDGE, 5 SW_EDGE, 6 CTRL, 7 BLANK
in  in  DBITS  write data
out  out  DBITS  read data (combinational from addr)
irq  out  1  interrupt request, level
KEYS  in  NKEYS  raw keys (asynchronous)
SWITCHES  in  NSW  raw switches (asynchronous)
LED  out  NLEDS  LED drive
HEX  out  7*NHEX  segments, digit i at [7i+6:7i], active-low, bit order g..a

Behaviour:
- Reset (async, active-high): sync flops, debounce counters, debounced values, LEDR, HEX, KEY_EDGE, SW_EDGE, CTRL, BLANK all cleared to 0. LED=0; every HEX digit shows "0" (7'b1000000); irq=0. Reset mid-debounce discards the partial count.
- Per input bit: 2-flop synchroniser, then a counter. Count increments while synced != debounced and clears when they are equal. On the edge where the count == DEB_CYCLES-1 with a mismatch, debounced <= synced and count <= 0. A clean step on the raw input therefore reaches the debounced value 2+DEB_CYCLES edges later. A glitch shorter than DEB_CYCLES synced cycles never propagates.
- Edge capture: a registered copy of each debounced bit. KEY_EDGE[i]/SW_EDGE[i] set on the edge after debounced bit i goes 0->1; bits are sticky.
- Writes (wrtEn=1, rising clk): LEDR <= in[NLEDS-1:0]; HEX <= in[4*NHEX-1:0]; CTRL <= in[1:0]. For KEY_EDGE/SW_EDGE, write-1-to-clear per bit. Same-cycle set and clear of a bit: set wins. Writes to KEY/SW are ignored.
- Reads (combinational): each register zero-extended to DBITS. KEY/SW return debounced values. Addresses with no register read 0 (never Z).
- CTRL bit0 = key IE, bit1 = switch IE. irq = (|KEY_EDGE & CTRL[0]) | (|SW_EDGE & CTRL[1]), combinational from registers.
- HEX decode: nibble 0-F maps to standard glyphs 0-9, A, b, C, d, E, F, active-low.

Optional Feature:
UI_HEX_BLANK_EN. Defined: addr 7 is BLANK, NHEX bits, written from in[NHEX-1:0], readable. A digit with its BLANK bit set drives 7'b1111111 (all segments off). Undefined: addr 7 reads 0, writes are ignored, and digits are never blanked.

Test Plan:
- Reset check: assert reset with clk stopped -> LED=0, every HEX digit=7'b1000000, irq=0, all reads return 0.
- Debounce latency, DEB_CYCLES=15: step KEYS[2] 0->1 and hold -> reading addr0 returns 0x4 exactly 17 edges after the step. A 10-cycle pulse on SWITCHES[0] leaves addr1 at 0.
- Edge capture and interrupt: write CTRL=1, then press KEYS[0] -> KEY_EDGE=0x1 and irq=1. Write 0x1 to addr4 -> KEY_EDGE=0, irq=0. Repeat with CTRL=0 -> irq stays 0.
- Set/clear collision: write 0x1 to addr4 on the same edge KEY_EDGE[0] sets -> bit reads 1.
- LED/HEX writes: write addr2=0xFFFFF3A5 -> LED=0x3A5 (NLEDS=10). Write addr3=0x00001B2F -> digits 3..0 show 1, b, 2, F. addr5/unused address reads 0.
- With UI_HEX_BLANK_EN: write BLANK=0xA -> digits 1 and 3 drive 7'b1111111 and addr7 reads 0xA. Without the macro: addr7 reads 0 after the same write.

Source files
------------

// File: rtl/ui_io_ctrl_if.sv
// Processor I/O bus bundle for ui_io_ctrl: write strobe, register select,
// write data and combinational read data.
interface ui_io_ctrl_if #(
    parameter int DBITS = 32
);
    logic             wrtEn;
    logic [2:0]       addr;
    logic [DBITS-1:0] in;
    logic [DBITS-1:0] out;

    // Bus protocol: a write happens on every rising clk where wrtEn=1, with
    // addr/in sampled on that edge; out follows addr combinationally.
    modport master (output wrtEn, addr, in, input out);
    modport slave  (input wrtEn, addr, in, output out);
endinterface

// File: rtl/ui_io_ctrl.sv
// Memory-mapped UI controller: debounced keys/switches, sticky edge capture,
// maskable irq, LED and seven-segment HEX. Optional UI_HEX_BLANK_EN adds BLANK.
module ui_io_ctrl #(
    parameter int DBITS      = 32,
    parameter int NKEYS      = 4,
    parameter int NSW        = 10,
    parameter int NLEDS      = 10,
    parameter int NHEX       = 4,
    parameter int DEB_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset,
    ui_io_ctrl_if.slave       bus,
    output logic              irq,
    input  logic [NKEYS-1:0]  KEYS,
    input  logic [NSW-1:0]    SWITCHES,
    output logic [NLEDS-1:0]  LED,
    output logic [7*NHEX-1:0] HEX
);
    localparam int NIN = NKEYS + NSW;
    localparam int CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    localparam logic [2:0] A_KEY = 3'd0, A_SW = 3'd1, A_LEDR = 3'd2, A_HEX = 3'd3;
    localparam logic [2:0] A_KEY_EDGE = 3'd4, A_SW_EDGE = 3'd5, A_CTRL = 3'd6, A_BLANK = 3'd7;

    logic [NIN-1:0]    sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
    logic [CW-1:0]     cnt_q [NIN];
    logic [CW-1:0]     cnt_d [NIN];
    logic [NLEDS-1:0]  ledr_q;
    logic [4*NHEX-1:0] hex_q;
    logic [NKEYS-1:0]  key_edge_q, key_edge_d;
    logic [NSW-1:0]    sw_edge_q, sw_edge_d;
    logic [1:0]        ctrl_q;
    logic [NHEX-1:0]   blank_mask;
    logic              unused_in;

    assign unused_in = ^bus.in;

    // The counter only runs while the synchronised input disagrees with the
    // debounced value, so any agreement restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) deb_d[i] = sync2_q[i];
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    logic wr_key_edge, wr_sw_edge;
    assign wr_key_edge = bus.wrtEn && (bus.addr == A_KEY_EDGE);
    assign wr_sw_edge  = bus.wrtEn && (bus.addr == A_SW_EDGE);

    // Rising-edge set is OR-ed in after the clear so a collision keeps the bit.
    always_comb begin
        key_edge_d = key_edge_q;
        sw_edge_d  = sw_edge_q;
        if (wr_key_edge) key_edge_d = key_edge_d & ~bus.in[NKEYS-1:0];
        if (wr_sw_edge)  sw_edge_d  = sw_edge_d & ~bus.in[NSW-1:0];
        key_edge_d = key_edge_d | (deb_q[NKEYS-1:0] & ~deb_prev_q[NKEYS-1:0]);
        sw_edge_d  = sw_edge_d | (deb_q[NIN-1:NKEYS] & ~deb_prev_q[NIN-1:NKEYS]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
            ledr_q     <= '0;
            hex_q      <= '0;
            key_edge_q <= '0;
            sw_edge_q  <= '0;
            ctrl_q     <= '0;
        end else begin
            sync1_q    <= {SWITCHES, KEYS};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
            key_edge_q <= key_edge_d;
            sw_edge_q  <= sw_edge_d;
            if (bus.wrtEn && bus.addr == A_LEDR) ledr_q <= bus.in[NLEDS-1:0];
            if (bus.wrtEn && bus.addr == A_HEX)  hex_q  <= bus.in[4*NHEX-1:0];
            if (bus.wrtEn && bus.addr == A_CTRL) ctrl_q <= bus.in[1:0];
        end
    end

`ifdef UI_HEX_BLANK_EN
    logic [NHEX-1:0] blank_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 blank_q <= '0;
        else if (bus.wrtEn && bus.addr == A_BLANK) blank_q <= bus.in[NHEX-1:0];
    end
    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        bus.out = '0;
        case (bus.addr)
            A_KEY:      bus.out = DBITS'(deb_q[NKEYS-1:0]);
            A_SW:       bus.out = DBITS'(deb_q[NIN-1:NKEYS]);
            A_LEDR:     bus.out = DBITS'(ledr_q);
            A_HEX:      bus.out = DBITS'(hex_q);
            A_KEY_EDGE: bus.out = DBITS'(key_edge_q);
            A_SW_EDGE:  bus.out = DBITS'(sw_edge_q);
            A_CTRL:     bus.out = DBITS'(ctrl_q);
            A_BLANK:    bus.out = DBITS'(blank_mask);
            default:    bus.out = '0;
        endcase
    end

    assign irq = ((|key_edge_q) & ctrl_q[0]) | ((|sw_edge_q) & ctrl_q[1]);
    assign LED = ledr_q;

    // Segment order g..a, active-low.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        HEX = '1;
        for (int d = 0; d < NHEX; d++)
            HEX[7*d +: 7] = blank_mask[d] ? 7'b1111111 : hex_glyph(hex_q[4*d +: 4]);
    end
endmodule

// File: tb/tb_ui_io_ctrl.sv
// Directed self-checking bench for ui_io_ctrl (default parameters).
module tb_ui_io_ctrl;
    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset;
    logic        irq;
    logic [3:0]  KEYS;
    logic [9:0]  SWITCHES;
    logic [9:0]  LED;
    logic [27:0] HEX;
    int          n_cmp = 0;
    int          n_fail = 0;

    ui_io_ctrl_if #(.DBITS(32)) bus();

    ui_io_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus), .irq(irq),
        .KEYS(KEYS), .SWITCHES(SWITCHES), .LED(LED), .HEX(HEX)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] GB = 7'b0000011, GF = 7'b0001110, OFF = 7'b1111111;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wrtEn = 1'b1; bus.addr = a; bus.in = d;
        @(negedge clk);
        bus.wrtEn = 1'b0; bus.in = '0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.out;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        reset = 1'b1; KEYS = '0; SWITCHES = '0;
        bus.wrtEn = 1'b0; bus.addr = '0; bus.in = '0;
        #2;
        n_cmp++; if (LED !== 10'h0) begin $display("FAIL reset_led got=%h exp=0", LED); n_fail++; end
        n_cmp++; if (HEX !== {G0, G0, G0, G0}) begin $display("FAIL reset_hex got=%h exp=%h", HEX, {G0, G0, G0, G0}); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", irq); n_fail++; end
        for (int a = 0; a < 8; a++) begin
            read_reg(3'(a), r);
            n_cmp++; if (r !== 32'h0) begin $display("FAIL reset_read addr=%0d got=%h exp=0", a, r); n_fail++; end
        end
        reset = 1'b0;
        #2;
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce;
        logic [31:0] r;
        @(negedge clk);
        KEYS[2] = 1'b1;
        repeat (16) @(posedge clk);
        @(negedge clk); read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL deb_edge16 got=%h exp=0", r); n_fail++; end
        @(posedge clk);
        @(negedge clk); read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h4) begin $display("FAIL deb_edge17 got=%h exp=4", r); n_fail++; end
        repeat (3) @(negedge clk);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h4) begin $display("FAIL deb_key_edge got=%h exp=4", r); n_fail++; end
        bus_write(3'd4, 32'h4);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL deb_key_edge_clr got=%h exp=0", r); n_fail++; end
        KEYS[2] = 1'b0;
        repeat (20) @(negedge clk);
        read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL deb_release got=%h exp=0", r); n_fail++; end
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL deb_fall_no_edge got=%h exp=0", r); n_fail++; end
    endtask

    task automatic test_glitch;
        logic [31:0] r;
        @(negedge clk);
        SWITCHES[0] = 1'b1;
        repeat (10) @(negedge clk);
        SWITCHES[0] = 1'b0;
        repeat (25) @(negedge clk);
        read_reg(3'd1, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL glitch_sw got=%h exp=0", r); n_fail++; end
        read_reg(3'd5, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL glitch_sw_edge got=%h exp=0", r); n_fail++; end
    endtask

    task automatic test_edge_irq;
        logic [31:0] r;
        bus_write(3'd6, 32'h1);
        KEYS[0] = 1'b1;
        repeat (20) @(negedge clk);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h1) begin $display("FAIL irq_key_edge got=%h exp=1", r); n_fail++; end
        n_cmp++; if (irq !== 1'b1) begin $display("FAIL irq_key_set got=%b exp=1", irq); n_fail++; end
        bus_write(3'd4, 32'h1);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL irq_key_clr got=%h exp=0", r); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL irq_after_clr got=%b exp=0", irq); n_fail++; end
        KEYS[0] = 1'b0;
        repeat (20) @(negedge clk);
        bus_write(3'd6, 32'h0);
        KEYS[0] = 1'b1;
        repeat (20) @(negedge clk);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h1) begin $display("FAIL masked_key_edge got=%h exp=1", r); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL masked_irq got=%b exp=0", irq); n_fail++; end
        bus_write(3'd4, 32'h1);
        KEYS[0] = 1'b0;
        repeat (20) @(negedge clk);
        bus_write(3'd6, 32'h2);
        SWITCHES[3] = 1'b1;
        repeat (20) @(negedge clk);
        read_reg(3'd5, r);
        n_cmp++; if (r !== 32'h8) begin $display("FAIL sw_edge got=%h exp=8", r); n_fail++; end
        n_cmp++; if (irq !== 1'b1) begin $display("FAIL sw_irq got=%b exp=1", irq); n_fail++; end
        read_reg(3'd1, r);
        n_cmp++; if (r !== 32'h8) begin $display("FAIL sw_read got=%h exp=8", r); n_fail++; end
        bus_write(3'd5, 32'h8);
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL sw_irq_clr got=%b exp=0", irq); n_fail++; end
        SWITCHES[3] = 1'b0;
        bus_write(3'd6, 32'h0);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_collision;
        logic [31:0] r;
        @(negedge clk);
        KEYS[0] = 1'b1;
        repeat (17) @(posedge clk);
        @(negedge clk);
        bus.wrtEn = 1'b1; bus.addr = 3'd4; bus.in = 32'h1;
        @(negedge clk);
        bus.wrtEn = 1'b0; bus.in = '0;
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h1) begin $display("FAIL collision_set_wins got=%h exp=1", r); n_fail++; end
        bus_write(3'd4, 32'h1);
        read_reg(3'd4, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL collision_later_clr got=%h exp=0", r); n_fail++; end
        KEYS[0] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        @(negedge clk);
        KEYS[1] = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; #1; reset = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk); read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL rstmid_edge16 got=%h exp=0", r); n_fail++; end
        @(posedge clk);
        @(negedge clk); read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h2) begin $display("FAIL rstmid_edge17 got=%h exp=2", r); n_fail++; end
        repeat (3) @(negedge clk);
        bus_write(3'd4, 32'hF);
        KEYS[1] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_led_hex;
        logic [31:0] r;
        bus_write(3'd2, 32'hFFFFF3A5);
        n_cmp++; if (LED !== 10'h3A5) begin $display("FAIL led_out got=%h exp=3a5", LED); n_fail++; end
        read_reg(3'd2, r);
        n_cmp++; if (r !== 32'h3A5) begin $display("FAIL led_read got=%h exp=3a5", r); n_fail++; end
        bus_write(3'd3, 32'h00001B2F);
        n_cmp++; if (HEX !== {G1, GB, G2, GF}) begin $display("FAIL hex_out got=%h exp=%h", HEX, {G1, GB, G2, GF}); n_fail++; end
        read_reg(3'd3, r);
        n_cmp++; if (r !== 32'h1B2F) begin $display("FAIL hex_read got=%h exp=1b2f", r); n_fail++; end
        bus_write(3'd0, 32'hF);
        read_reg(3'd0, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL key_write_ignored got=%h exp=0", r); n_fail++; end
        read_reg(3'd5, r);
        n_cmp++; if (r !== 32'h0) begin $display("FAIL sw_edge_idle got=%h exp=0", r); n_fail++; end
        bus_write(3'd6, 32'hFFFFFFFE);
        read_reg(3'd6, r);
        n_cmp++; if (r !== 32'h2) begin $display("FAIL ctrl_read got=%h exp=2", r); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL ctrl_no_edges_irq got=%b exp=0", irq); n_fail++; end
    endtask

    task automatic test_blank;
        logic [31:0] r;
        bus_write(3'd7, 32'hA);
        read_reg(3'd7, r);
`ifdef UI_HEX_BLANK_EN
        n_cmp++; if (HEX !== {OFF, GB, OFF, GF}) begin $display("FAIL blank_hex got=%h exp=%h", HEX, {OFF, GB, OFF, GF}); n_fail++; end
        n_cmp++; if (r !== 32'hA) begin $display("FAIL blank_read got=%h exp=a", r); n_fail++; end
`else
        n_cmp++; if (HEX !== {G1, GB, G2, GF}) begin $display("FAIL noblank_hex got=%h exp=%h", HEX, {G1, GB, G2, GF}); n_fail++; end
        n_cmp++; if (r !== 32'h0) begin $display("FAIL noblank_read got=%h exp=0", r); n_fail++; end
`endif
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_glitch;
        test_edge_irq;
        test_collision;
        test_reset_mid;
        test_led_hex;
        test_blank;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
